// File: rtl/img_matrix_gen_3_3.sv
// 3x3 neighbourhood generator: turns a raster pixel stream into fully-interior 3x3 windows
// using two line buffers and a 3x3 shift window; no border padding is produced.
module img_matrix_gen_3_3 #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_en,
  input  logic [DATA_W-1:0] pix_data,
  output logic              matrix_en,
  output logic [DATA_W-1:0] matrix_p11,
  output logic [DATA_W-1:0] matrix_p12,
  output logic [DATA_W-1:0] matrix_p13,
  output logic [DATA_W-1:0] matrix_p21,
  output logic [DATA_W-1:0] matrix_p22,
  output logic [DATA_W-1:0] matrix_p23,
  output logic [DATA_W-1:0] matrix_p31,
  output logic [DATA_W-1:0] matrix_p32,
  output logic [DATA_W-1:0] matrix_p33,
  output logic              frame_done
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_END  = RW'(IMG_HEIGHT);

  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  logic [DATA_W-1:0] lb1 [IMG_WIDTH];
  logic [DATA_W-1:0] lb2 [IMG_WIDTH];
  logic [DATA_W-1:0] win_reg [3][3];
  logic [DATA_W-1:0] out_reg [3][3];
  logic [DATA_W-1:0] new_col [3];
  logic              accept;
  logic              interior;

  // frame_start has priority over a coincident pixel, which is dropped
  assign accept   = pix_en && !frame_start && (row_reg < ROW_END);
  assign interior = (row_reg >= RW'(2)) && (col_reg >= CW'(2));

  assign new_col[0] = lb2[col_reg];
  assign new_col[1] = lb1[col_reg];
  assign new_col[2] = pix_data;

  always_ff @(posedge clk) begin
    if (accept) begin
      lb2[col_reg] <= lb1[col_reg];
      lb1[col_reg] <= pix_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_reg    <= '0;
      row_reg    <= '0;
      matrix_en  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      matrix_en  <= accept && interior;
      frame_done <= accept && (row_reg == ROW_LAST) && (col_reg == COL_LAST);
      if (frame_start) begin
        col_reg <= '0;
        row_reg <= '0;
      end else if (accept) begin
        if (col_reg == COL_LAST) begin
          col_reg <= '0;
          row_reg <= row_reg + RW'(1);
        end else begin
          col_reg <= col_reg + CW'(1);
        end
      end
    end
  end

  // The window shifts on every accepted pixel (priming included); the output copy only
  // updates on interior pixels so outputs hold steady while matrix_en is low.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_row
      always_ff @(posedge clk) begin
        if (rst) begin
          win_reg[gi][0] <= '0;
          win_reg[gi][1] <= '0;
          win_reg[gi][2] <= '0;
          out_reg[gi][0] <= '0;
          out_reg[gi][1] <= '0;
          out_reg[gi][2] <= '0;
        end else if (accept) begin
          win_reg[gi][0] <= win_reg[gi][1];
          win_reg[gi][1] <= win_reg[gi][2];
          win_reg[gi][2] <= new_col[gi];
          if (interior) begin
            out_reg[gi][0] <= win_reg[gi][1];
            out_reg[gi][1] <= win_reg[gi][2];
            out_reg[gi][2] <= new_col[gi];
          end
        end
      end
    end
  endgenerate

  assign matrix_p11 = out_reg[0][0];
  assign matrix_p12 = out_reg[0][1];
  assign matrix_p13 = out_reg[0][2];
  assign matrix_p21 = out_reg[1][0];
  assign matrix_p22 = out_reg[1][1];
  assign matrix_p23 = out_reg[1][2];
  assign matrix_p31 = out_reg[2][0];
  assign matrix_p32 = out_reg[2][1];
  assign matrix_p33 = out_reg[2][2];

endmodule

// File: tb/tb_img_matrix_gen_3_3.sv
// Bench for img_matrix_gen_3_3: a 4x3 and a 7x5 instance, a full-frame reference model and a
// scoreboard queue of expected windows popped whenever matrix_en appears.
module tb_img_matrix_gen_3_3;
  localparam int WA = 4, HA = 3, WB = 7, HB = 5;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       fs = 1'b0;
  logic       pe = 1'b0;
  logic [7:0] pd = 8'h00;
  logic       en_a, fd_a, en_b, fd_b;
  logic [7:0] pa [9];
  logic [7:0] pb [9];

  always #5 clk = ~clk;

  img_matrix_gen_3_3 #(.IMG_WIDTH(WA), .IMG_HEIGHT(HA), .DATA_W(8)) dut_a (
    .clk(clk), .rst(rst), .frame_start(fs), .pix_en(pe), .pix_data(pd),
    .matrix_en(en_a),
    .matrix_p11(pa[0]), .matrix_p12(pa[1]), .matrix_p13(pa[2]),
    .matrix_p21(pa[3]), .matrix_p22(pa[4]), .matrix_p23(pa[5]),
    .matrix_p31(pa[6]), .matrix_p32(pa[7]), .matrix_p33(pa[8]),
    .frame_done(fd_a));

  img_matrix_gen_3_3 #(.IMG_WIDTH(WB), .IMG_HEIGHT(HB), .DATA_W(8)) dut_b (
    .clk(clk), .rst(rst), .frame_start(fs), .pix_en(pe), .pix_data(pd),
    .matrix_en(en_b),
    .matrix_p11(pb[0]), .matrix_p12(pb[1]), .matrix_p13(pb[2]),
    .matrix_p21(pb[3]), .matrix_p22(pb[4]), .matrix_p23(pb[5]),
    .matrix_p31(pb[6]), .matrix_p32(pb[7]), .matrix_p33(pb[8]),
    .frame_done(fd_b));

  typedef struct packed {
    logic [71:0] win;
    logic        fd;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  int          sel = 0;
  int          m_w = WA, m_h = HA, m_row = 0, m_col = 0;
  int          n_en = 0, n_fd = 0;
  logic [7:0]  img [8][8];
  logic [71:0] last_win = '0;

  function automatic logic [71:0] dut_win();
    logic [71:0] w;
    w = '0;
    for (int i = 0; i < 9; i++) w = {w[63:0], (sel != 0) ? pb[i] : pa[i]};
    return w;
  endfunction

  // Drive one cycle, advance the reference model, then check outputs on the falling edge.
  task automatic step(input logic r, input logic f, input logic e, input logic [7:0] d);
    logic        exp_en, got_en, got_fd, acc;
    logic [71:0] w, got_w;
    exp_t        x;
    rst = r; fs = f; pe = e; pd = d;
    exp_en = 1'b0;
    if (r) begin
      m_row = 0; m_col = 0; last_win = '0;
      sbq.delete();
    end else begin
      acc = e && !f && (m_row < m_h);
      if (acc) begin
        img[m_row][m_col] = d;
        if (m_row >= 2 && m_col >= 2) begin
          w = '0;
          for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
              w = {w[63:0], img[m_row-2+rr][m_col-2+cc]};
          x.win = w;
          x.fd  = (m_row == m_h - 1) && (m_col == m_w - 1);
          sbq.push_back(x);
          exp_en = 1'b1;
        end
        if (m_col == m_w - 1) begin
          m_col = 0; m_row++;
        end else begin
          m_col++;
        end
      end
      if (f) begin
        m_row = 0; m_col = 0;
      end
    end
    @(negedge clk);
    got_en = (sel != 0) ? en_b : en_a;
    got_fd = (sel != 0) ? fd_b : fd_a;
    got_w  = dut_win();
    checks++;
    if (got_en !== exp_en) begin
      errors++;
      $display("FAIL matrix_en t=%0t got %b want %b", $time, got_en, exp_en);
    end
    if (got_en === 1'b1) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_window t=%0t got %h want none", $time, got_w);
      end else begin
        x = sbq.pop_front();
        if (got_w !== x.win || got_fd !== x.fd) begin
          errors++;
          $display("FAIL window t=%0t got %h fd=%b want %h fd=%b", $time, got_w, got_fd, x.win, x.fd);
        end
        last_win = x.win;
      end
      n_en++;
      if (got_fd === 1'b1) n_fd++;
    end else begin
      checks++;
      if (got_w !== last_win || got_fd !== 1'b0) begin
        errors++;
        $display("FAIL hold t=%0t got %h fd=%b want %h fd=0", $time, got_w, got_fd, last_win);
      end
    end
  endtask

  task automatic send_frame(input int gapmax, input logic [7:0] base, input bit rnd);
    for (int r = 0; r < m_h; r++)
      for (int c = 0; c < m_w; c++) begin
        int gaps;
        gaps = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
        for (int g = 0; g < gaps; g++) step(1'b0, 1'b0, 1'b0, 8'($urandom));
        step(1'b0, 1'b0, 1'b1, rnd ? 8'($urandom) : 8'(int'(base) + 16 * r + c));
      end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'($urandom), 8'($urandom));
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (dut_win() !== 72'h0) begin
      errors++;
      $display("FAIL reset_window got %h want 0", dut_win());
    end
  endtask

  task automatic check_t1(input string name, input int en0, input int fd0, input logic [71:0] want);
    checks++;
    if (n_en - en0 != 2 || n_fd - fd0 != 1) begin
      errors++;
      $display("FAIL %s_count got en=%0d fd=%0d want en=2 fd=1", name, n_en - en0, n_fd - fd0);
    end
    checks++;
    if (dut_win() !== want) begin
      errors++;
      $display("FAIL %s_last got %h want %h", name, dut_win(), want);
    end
  endtask

  task automatic test_basic();
    int en0, fd0;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    en0 = n_en; fd0 = n_fd;
    send_frame(0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_t1("basic", en0, fd0, 72'h01_02_03_11_12_13_21_22_23);
  endtask

  task automatic test_gaps();
    int en0, fd0;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    en0 = n_en; fd0 = n_fd;
    send_frame(5, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_t1("gaps", en0, fd0, 72'h01_02_03_11_12_13_21_22_23);
  endtask

  task automatic test_overrun();
    int en0, fd0;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    send_frame(0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h55 + i));
    step(1'b0, 1'b1, 1'b0, 8'h00);
    en0 = n_en; fd0 = n_fd;
    send_frame(0, 8'h80, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_t1("overrun", en0, fd0, 72'h81_82_83_91_92_93_a1_a2_a3);
  endtask

  task automatic test_fs_coincide();
    int en0, fd0;
    step(1'b0, 1'b1, 1'b1, 8'hee);
    en0 = n_en; fd0 = n_fd;
    send_frame(0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_t1("fs_coincide", en0, fd0, 72'h01_02_03_11_12_13_21_22_23);
  endtask

  task automatic test_reset_mid();
    int en0, fd0;
    step(1'b0, 1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 1'b1, 8'(8'h40 + i));
    step(1'b1, 1'b0, 1'b1, 8'h99);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (dut_win() !== 72'h0 || en_a !== 1'b0 || fd_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_idle got %h en=%b fd=%b want 0", dut_win(), en_a, fd_a);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    en0 = n_en; fd0 = n_fd;
    send_frame(0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    check_t1("reset_mid", en0, fd0, 72'h01_02_03_11_12_13_21_22_23);
  endtask

  task automatic test_random();
    int en0, fd0;
    sel = 1; m_w = WB; m_h = HB;
    test_reset();
    en0 = n_en; fd0 = n_fd;
    for (int f = 0; f < 3; f++) begin
      step(1'b0, 1'b1, 1'b0, 8'h00);
      send_frame(2, 8'h00, 1'b1);
    end
    step(1'b0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (n_en - en0 != 3 * (WB - 2) * (HB - 2) || n_fd - fd0 != 3) begin
      errors++;
      $display("FAIL random_count got en=%0d fd=%0d want en=%0d fd=3",
               n_en - en0, n_fd - fd0, 3 * (WB - 2) * (HB - 2));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gaps();
    test_overrun();
    test_fs_coincide();
    test_reset_mid();
    test_random();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d pending want 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
